// File: rtl/adrv9001_rx_capture_pkg.sv
// Shared types and sizing for the ADRV9001 receive burst-capture stage.
package adrv9001_rx_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SKIP,
    CAPTURE,
    DRAIN
  } state_t;

  localparam int DEFAULT_FIFO_DEPTH = 16;
  localparam int ADDR_W = $clog2(DEFAULT_FIFO_DEPTH);

endpackage

// File: rtl/adrv9001_rx_capture_fifo.sv
// First-word-fall-through FIFO holding one captured burst.
module adrv9001_rx_capture_fifo
  import adrv9001_rx_capture_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_ptr];
  // A pop in the same cycle frees a slot, so a write into a full FIFO is legal then.
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adrv9001_rx_capture.sv
// Triggered burst capture of the ADRV9001 RX IQ stream, replayed on an AXI-stream master.
module adrv9001_rx_capture
  import adrv9001_rx_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  clear_overflow,
  input  logic                  trigger,
  input  logic [CNT_WIDTH-1:0]  skip_len,
  input  logic [CNT_WIDTH-1:0]  capture_len,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LAST_WORD = 1;

  state_t                state;
  logic                  trigger_d;
  logic                  trig_edge;
  logic [CNT_WIDTH-1:0]  skip_cnt;
  logic [CNT_WIDTH-1:0]  cap_cnt;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [AW:0]           fifo_count;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  rd_fire;
  logic                  wr_room;
  logic                  wr_en;

  assign trig_edge     = trigger & ~trigger_d;
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_data;
  assign m_axis_tlast  = (state == DRAIN) & m_axis_tvalid & (fifo_count == LAST_WORD);
  assign busy          = (state != IDLE);
  // Abort overrides any pop or push occurring in the same cycle.
  assign rd_fire       = m_axis_tvalid & m_axis_tready & ~abort;
  assign wr_room       = ~fifo_full | rd_fire;
  assign wr_en         = (state == CAPTURE) & s_axis_tvalid & wr_room & (cap_cnt != '0) & ~abort;

  adrv9001_rx_capture_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort),
    .wr_en   (wr_en),
    .wr_data (s_axis_tdata),
    .rd_en   (rd_fire),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      trigger_d <= 1'b0;
      skip_cnt  <= '0;
      cap_cnt   <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      trigger_d <= trigger;
      done      <= 1'b0;
      if (clear_overflow) overflow <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              skip_cnt <= skip_len;
              cap_cnt  <= capture_len;
              if (capture_len == '0) done <= 1'b1;
              else                   state <= ARMED;
            end
          end
          ARMED: begin
            if (trig_edge) state <= (skip_cnt != '0) ? SKIP : CAPTURE;
          end
          SKIP: begin
            if (s_axis_tvalid && skip_cnt != '0) begin
              skip_cnt <= skip_cnt - 1'b1;
              if (skip_cnt == 1) state <= CAPTURE;
            end
          end
          CAPTURE: begin
            // A sample with nowhere to go ends the capture early and is dropped.
            if (s_axis_tvalid) begin
              if (!wr_room) begin
                overflow <= 1'b1;
                state    <= DRAIN;
              end else if (cap_cnt != '0) begin
                cap_cnt <= cap_cnt - 1'b1;
                if (cap_cnt == 1) state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (fifo_empty) begin
              state <= IDLE;
            end else if (rd_fire && fifo_count == LAST_WORD) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adrv9001_rx_capture.sv
// Directed self-checking bench for adrv9001_rx_capture.
module tb_adrv9001_rx_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        trigger = 1'b0;
  logic [15:0] skip_len = '0;
  logic [15:0] capture_len = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic        overflow;

  int          check_count = 0;
  int          error_count = 0;
  int          done_count = 0;
  int          period = 0;
  int          cyc = 0;
  logic [31:0] sample_val = '0;
  logic [32:0] out_q[$];

  always #5 clk = ~clk;

  adrv9001_rx_capture #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (16),
    .CNT_WIDTH  (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .arm            (arm),
    .abort          (abort),
    .clear_overflow (clear_overflow),
    .trigger        (trigger),
    .skip_len       (skip_len),
    .capture_len    (capture_len),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  // Record every accepted output word and every done pulse away from the active edge.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
    if (done) done_count++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one cycle and present the next stream slot (a valid every 'period' cycles).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    s_axis_tvalid = 1'b0;
    if (period != 0) begin
      if ((cyc % period) == 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = sample_val;
        sample_val    = sample_val + 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] skip, input logic [15:0] cap);
    skip_len    = skip;
    capture_len = cap;
    arm         = 1'b1;
    tick();
    arm         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    period = 0;
    trigger = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    clear_overflow = 1'b0;
    m_axis_tready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sample_val = '0;
    cyc = 0;
    tick();
    out_q.delete();
    done_count = 0;
  endtask

  task automatic wait_sample(input logic [31:0] v);
    int n = 0;
    while (!(s_axis_tvalid && s_axis_tdata == v) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("sample_wait", 32'(n < 200), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    checkOutput("done_wait", 32'(n < 400), 1);
  endtask

  task automatic check_burst(input logic [31:0] first, input int n);
    checkOutput("burst_len", 32'(out_q.size()), 32'(n));
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      checkOutput("burst_data", out_q[i][31:0], first + 32'(i));
      checkOutput("burst_last", 32'(out_q[i][32]), 32'(i == n - 1));
    end
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] prev;
    int          n;
    int          busy_drops;

    tick();
    checkOutput("rst_tvalid", 32'(m_axis_tvalid), 0);
    checkOutput("rst_tdata", m_axis_tdata, 0);
    checkOutput("rst_tlast", 32'(m_axis_tlast), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);

    // Skip 3, capture 5, trigger on sample 10.
    do_reset();
    m_axis_tready = 1'b1;
    period = 1;
    applyStimulus(16'd3, 16'd5);
    checkOutput("t1_busy", 32'(busy), 1);
    wait_sample(32'd10);
    trigger = 1'b1;
    tick();
    wait_done();
    tick();
    check_burst(32'd14, 5);
    checkOutput("t1_done_count", 32'(done_count), 1);
    checkOutput("t1_overflow", 32'(overflow), 0);
    trigger = 1'b0;

    // Sparse valids: first-sample latency and busy span.
    do_reset();
    m_axis_tready = 1'b1;
    period = 4;
    applyStimulus(16'd0, 16'd8);
    n = 0;
    while (s_axis_tvalid && n < 10) begin tick(); n++; end
    trigger = 1'b1;
    tick();
    n = 0;
    while (!s_axis_tvalid && n < 10) begin tick(); n++; end
    v = s_axis_tdata;
    checkOutput("t2_pre_tvalid", 32'(m_axis_tvalid), 0);
    tick();
    checkOutput("t2_lat_tvalid", 32'(m_axis_tvalid), 1);
    checkOutput("t2_lat_tdata", m_axis_tdata, v);
    busy_drops = 0;
    n = 0;
    while (!done && n < 400) begin
      if (!busy) busy_drops++;
      tick();
      n++;
    end
    checkOutput("t2_done_seen", 32'(done), 1);
    checkOutput("t2_busy_drops", 32'(busy_drops), 0);
    checkOutput("t2_busy_after", 32'(busy), 0);
    tick();
    check_burst(v, 8);
    trigger = 1'b0;

    // Overflow with tready low, then drain.
    do_reset();
    period = 1;
    applyStimulus(16'd0, 16'd40);
    wait_sample(32'd5);
    trigger = 1'b1;
    n = 0;
    prev = '0;
    while (!overflow && n < 100) begin
      prev = s_axis_tdata;
      tick();
      n++;
    end
    checkOutput("t3_overflow", 32'(overflow), 1);
    checkOutput("t3_ovf_sample", prev, 32'd22);
    checkOutput("t3_busy", 32'(busy), 1);
    checkOutput("t3_tvalid", 32'(m_axis_tvalid), 1);
    checkOutput("t3_tdata", m_axis_tdata, 32'd6);
    checkOutput("t3_tlast_early", 32'(m_axis_tlast), 0);
    period = 0;
    tick();
    m_axis_tready = 1'b1;
    wait_done();
    tick();
    check_burst(32'd6, 16);
    checkOutput("t3_done_count", 32'(done_count), 1);
    checkOutput("t3_overflow_sticky", 32'(overflow), 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checkOutput("t3_overflow_clr", 32'(overflow), 0);
    trigger = 1'b0;

    // Abort after 6 writes, then a clean burst.
    do_reset();
    period = 1;
    applyStimulus(16'd0, 16'd20);
    wait_sample(32'd3);
    trigger = 1'b1;
    tick();
    repeat (6) tick();
    checkOutput("t4_pre_tvalid", 32'(m_axis_tvalid), 1);
    checkOutput("t4_pre_tdata", m_axis_tdata, 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t4_busy", 32'(busy), 0);
    checkOutput("t4_flushed", 32'(m_axis_tvalid), 0);
    repeat (5) tick();
    checkOutput("t4_no_done", 32'(done_count), 0);
    trigger = 1'b0;
    tick();
    m_axis_tready = 1'b1;
    out_q.delete();
    applyStimulus(16'd1, 16'd3);
    v = s_axis_tdata + 32'd3;
    wait_sample(v);
    trigger = 1'b1;
    tick();
    wait_done();
    tick();
    check_burst(v + 32'd2, 3);
    checkOutput("t4_done_count", 32'(done_count), 1);
    trigger = 1'b0;

    // Zero-length capture.
    do_reset();
    applyStimulus(16'd0, 16'd0);
    checkOutput("t5_done", 32'(done), 1);
    checkOutput("t5_busy", 32'(busy), 0);
    tick();
    checkOutput("t5_done_end", 32'(done), 0);
    checkOutput("t5_busy_end", 32'(busy), 0);
    checkOutput("t5_no_output", 32'(out_q.size()), 0);

    // Arm with a simultaneous edge, then reset mid-capture.
    do_reset();
    period = 1;
    trigger = 1'b1;
    applyStimulus(16'd2, 16'd4);
    checkOutput("t6_armed_busy", 32'(busy), 1);
    repeat (10) tick();
    checkOutput("t6_no_capture", 32'(m_axis_tvalid), 0);
    trigger = 1'b0;
    tick();
    v = s_axis_tdata;
    trigger = 1'b1;
    tick();
    repeat (3) tick();
    checkOutput("t6_cap_tvalid", 32'(m_axis_tvalid), 1);
    checkOutput("t6_cap_tdata", m_axis_tdata, v + 32'd3);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_tvalid", 32'(m_axis_tvalid), 0);
    checkOutput("t6_rst_tdata", m_axis_tdata, 0);
    checkOutput("t6_rst_tlast", 32'(m_axis_tlast), 0);
    checkOutput("t6_rst_busy", 32'(busy), 0);
    checkOutput("t6_rst_done", 32'(done), 0);
    checkOutput("t6_rst_overflow", 32'(overflow), 0);
    trigger = 1'b0;
    period = 0;
    tick();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/adrv9001_rx_capture.md
Name: adrv9001_rx_capture

Overview:
Triggered burst-capture stage directly downstream of the ADRV9001 receive channel, in the receive data-clock domain.
Consumes the channel's free-running IQ stream (32-bit {I,Q}, valid-only, no backpressure).
After an arm and trigger it discards a programmable number of samples, captures a programmable number of samples into an internal FIFO, and replays them on a backpressured AXI-stream master with tlast on the final word.
Reports busy, done and a sticky overflow flag to software.

Parameters:
DATA_WIDTH, 32, IQ sample width ({I[15:0], Q[15:0]}).
FIFO_DEPTH, 16, capture FIFO entries; power of 2, minimum 4.
CNT_WIDTH, 16, width of the skip and capture length counters.

Ports:
clk  in  1  receive data clock (divided SSI clock); all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
s_axis_tdata  in  DATA_WIDTH  IQ sample from the receive channel.
s_axis_tvalid  in  1  sample valid; no tready, so the source never stalls.
arm  in  1  single-cycle request to arm a capture.
abort  in  1  single-cycle request to abort the capture and flush.
clear_overflow  in  1  clears the sticky overflow flag.
trigger  in  1  level input; a rising edge starts the capture.
skip_len  in  CNT_WIDTH  valid samples discarded after the trigger.
capture_len  in  CNT_WIDTH  valid samples captured.
m_axis_tdata  out  DATA_WIDTH  captured sample.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  downstream ready.
m_axis_tlast  out  1  final word of the burst.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse when a burst fully drains.
overflow  out  1  sticky; set when a capture write hits a full FIFO.

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; FIFO empty; trigger_d=0; counters 0. All outputs 0: m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, done, overflow.
- trigger_d <= trigger every cycle. Edge = trigger & ~trigger_d.
- States: IDLE, ARMED, SKIP, CAPTURE, DRAIN.
- IDLE:
  - arm=1 latches skip_len and capture_len.
  - capture_len==0: stay IDLE and pulse done next cycle.
  - otherwise go to ARMED.
  - Edges are ignored; arm and an edge in the same cycle act as arm only (that edge is lost).
- ARMED: on edge at cycle k, go to SKIP if skip_cnt>0, else CAPTURE, effective k+1. The sample on cycle k is not used.
- SKIP: each s_axis_tvalid decrements skip_cnt; the valid that takes skip_cnt 1->0 moves to CAPTURE. That sample is discarded.
- CAPTURE: each s_axis_tvalid writes the FIFO and decrements cap_cnt. The write taking cap_cnt 1->0 moves to DRAIN.
- Overflow: a valid arriving while the FIFO is full is dropped. Then overflow<=1, and state goes to DRAIN immediately (capture aborted).
- DRAIN: m_axis_tlast = m_axis_tvalid & (fifo_count==1). The pop of that word (tvalid & tready) returns to IDLE and pulses done for 1 cycle.
- FIFO:
  - First-word-fall-through.
  - A write at cycle n is visible on m_axis_tdata/tvalid at n+1.
  - Read and write in the same cycle are allowed when the FIFO is full (pop frees the slot first) and when it is empty (the word appears next cycle).
  - m_axis_tvalid = ~empty in any state.
  - tdata/tvalid stay stable while tvalid & ~tready.
- Outside DRAIN, m_axis_tlast=0.
- abort (any state): next state IDLE, FIFO flushed next cycle, no done pulse. Abort wins over arm, edge, write and read in the same cycle.
- arm while not IDLE is ignored.
- clear_overflow clears the flag. If a new overflow event occurs in the same cycle, set wins.
- Counters are unsigned CNT_WIDTH with no wrap; a counter is never decremented at 0.
- busy is combinational from state.

Decomposition:
- Package adrv9001_rx_capture_pkg holds:
  - a state enum type;
  - localparam ADDR_W = $clog2(FIFO_DEPTH).
- Sub-module adrv9001_rx_capture_fifo: synchronous FWFT FIFO with ports clk, rst, flush, wr_en, wr_data, rd_en, rd_data, empty, full, count.
- The FSM and counters live in the top module.

Test Plan:
1. skip_len=3, capture_len=5, continuous valid counting 0,1,2…, trigger edge on the cycle carrying value 10, tready=1 -> output words 14,15,16,17,18; tlast only on 18; done pulses once; overflow=0.
2. Valid every 4th cycle, skip_len=0, capture_len=8, tready=1 -> 8 words with the first-sample latency of 1 cycle; busy stays 1 from arm until the cycle after the final pop.
3. FIFO_DEPTH=16, capture_len=40, tready=0 -> 16 words retained; overflow=1 on the 17th valid; state DRAIN; raising tready emits 16 words with tlast on the 16th, then done.
4. Abort mid-CAPTURE after 6 writes -> IDLE next cycle; FIFO empty; no done; a subsequent arm + trigger captures a clean burst.
5. capture_len=0 plus arm -> done pulse 1 cycle later; busy never set; no output.
6. arm and trigger edge in the same IDLE cycle -> ARMED; nothing captured until the next edge. Assert rst mid-CAPTURE -> all outputs 0 immediately.
